// File: rtl/edge_uart_tx_if.sv
// Pixel strobe bundle between the edge-detection pipeline and the UART return path.
// The pipeline drives the master side; edge_uart_tx receives on the slave side.
interface edge_uart_tx_if;
    logic       pix_flag;
    logic [7:0] pix_data;

    modport master (output pix_flag, output pix_data);
    modport slave  (input  pix_flag, input  pix_data);
endinterface

// File: rtl/edge_uart_tx.sv
// UART transmit end of the edge-detection link: buffers pixel strobes in a FIFO and sends 8N1, LSB first.
// Optional macro TX_PARITY_EN adds an even-parity bit (8E1 frame).
//
// state    | meaning
// ---------|------------------------------------------------------------
// S_IDLE   | line idle, waiting for a byte in the FIFO
// S_START  | start bit (low) for one bit time
// S_DATA   | 8 data bits, LSB first
// S_PARITY | even-parity bit (only with TX_PARITY_EN)
// S_STOP   | stop bit (high); pops straight into the next frame if data waits
module edge_uart_tx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int BAUD_CNT_END = CLK_FREQ / BAUD - 1,
    parameter int FIFO_DEPTH   = 256,
    parameter int FIFO_AW      = 8
) (
    input  logic                sclk,
    input  logic                rst_n,
    edge_uart_tx_if.slave       pix,
    output logic                tx,
    output logic                busy,
    output logic                fifo_full,
    output logic                overflow
);

    localparam int BW = ($clog2(BAUD_CNT_END + 1) < 1) ? 1 : $clog2(BAUD_CNT_END + 1);
    localparam logic [BW-1:0]      BAUD_END = BW'(BAUD_CNT_END);
    localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 fifo_full_q, fifo_full_d;
    logic                 overflow_q, overflow_d;
`ifdef TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic                 pop;
    logic                 push;
    logic                 baud_wrap;
    logic                 fifo_nempty;
    logic [7:0]           head;

    assign head        = mem_q[rd_ptr_q];
    assign fifo_nempty = (count_q != '0);
    assign baud_wrap   = (baud_cnt_q == BAUD_END);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
`ifdef TX_PARITY_EN
        parity_d   = parity_q;
`endif

        // Counter only runs while a frame is on the line; every exit path leaves it at zero.
        if (state_q != S_IDLE) begin
            baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d = head;
`ifdef TX_PARITY_EN
            parity_d = ^head;
`endif
        end

        // A full FIFO still accepts a byte when the head leaves on the same edge.
        push = pix.pix_flag && ((count_q != DEPTH_C) || pop);

        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (FIFO_AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (FIFO_AW + 1)'(1);
        end

        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase

        busy_d      = (state_q != S_IDLE) || fifo_nempty;
        fifo_full_d = (count_q == DEPTH_C);
        overflow_d  = overflow_q || (pix.pix_flag && !push);
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            fifo_full_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            fifo_full_q <= fifo_full_d;
            overflow_q  <= overflow_d;
`ifdef TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pix.pix_data;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_full = fifo_full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_uart_tx.sv
// Bench for edge_uart_tx: directed frames plus random strobe traffic against a frame-timeline model.
// Honours TX_PARITY_EN to expect 11-bit frames.
module tb_edge_uart_tx;

    localparam int BIT   = 10;
    localparam int DEPTH = 4;
`ifdef TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic sclk  = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy, fifo_full, overflow;

    edge_uart_tx_if pif ();

    edge_uart_tx #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (DEPTH),
        .FIFO_AW    (2)
    ) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .pix       (pif),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt     = 0;

    // Model: queue of accepted bytes and the timeline of the frame currently on the line.
    logic [7:0] mq [$];
    logic [7:0] rx_q [$];
    int         fr_p      = 0;
    int         free_edge = 0;
    bit         fr_valid  = 1'b0;
    logic [7:0] fr_byte   = 8'h00;
    bit         m_ovf     = 1'b0;
    logic       e_tx = 1'b1, e_busy = 1'b0, e_full = 1'b0, e_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FRAME == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        mq.delete();
        fr_valid  = 1'b0;
        free_edge = 0;
        m_ovf     = 1'b0;
        e_tx      = 1'b1;
        e_busy    = 1'b0;
        e_full    = 1'b0;
        e_ovf     = 1'b0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge sclk);
            ecnt++;
            if (!rst_n) begin
                model_reset();
            end else begin
                bit on_line;
                // Outputs after this edge are registered from the state after the previous edge.
                on_line = fr_valid && (ecnt - 1 >= fr_p) && (ecnt - 1 < fr_p + FRAME * BIT);
                e_tx    = on_line ? frame_bit(fr_byte, (ecnt - 1 - fr_p) / BIT) : 1'b1;
                e_busy  = on_line || (mq.size() != 0);
                e_full  = (mq.size() == DEPTH);
                if (ecnt >= free_edge && mq.size() != 0) begin
                    fr_byte   = mq.pop_front();
                    fr_p      = ecnt;
                    fr_valid  = 1'b1;
                    free_edge = ecnt + FRAME * BIT;
                end
                if (pif.pix_flag === 1'b1) begin
                    if (mq.size() < DEPTH) mq.push_back(pif.pix_data);
                    else m_ovf = 1'b1;
                end
                e_ovf = m_ovf;
            end
        end
    end

    initial begin
        forever begin
            @(negedge rst_n);
            model_reset();
        end
    end

    initial begin
        forever begin
            @(negedge sclk);
            check("tx", {31'd0, tx}, {31'd0, e_tx});
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("fifo_full", {31'd0, fifo_full}, {31'd0, e_full});
            check("overflow", {31'd0, overflow}, {31'd0, e_ovf});
        end
    end

    // Line receiver: samples mid-bit and collects the data bytes.
    initial begin
        forever begin
            @(negedge sclk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                logic [7:0] b;
                tick(BIT / 2);
                for (int i = 0; i < 8; i++) begin
                    tick(BIT);
                    b[i] = tx;
                end
                rx_q.push_back(b);
                tick(BIT * (FRAME - 9));
            end
        end
    end

    task automatic send_seq(input logic [7:0] bytes [$]);
        foreach (bytes[i]) begin
            pif.pix_flag = 1'b1;
            pif.pix_data = bytes[i];
            tick(1);
        end
        pif.pix_flag = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        tick(2);
        while (busy !== 1'b0 && k < max) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (k >= max) begin
            n_fail++;
            $display("FAIL idle_wait: busy %b after %0d cycles, required 0", busy, max);
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp [$]);
        check({name, "_count"}, rx_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < rx_q.size()) check(name, {24'd0, rx_q[i]}, {24'd0, exp[i]});
        end
    endtask

    initial begin : main
        int a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int rates [6]   = '{3, 15, 50, 90, 8, 30};
        pif.pix_flag = 1'b0;
        pif.pix_data = 8'h00;

        // Reset values and quiet line after release.
        tick(5);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        tick(20);
        check("idle_tx", {31'd0, tx}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single 0xA5 frame with exact bit timing.
        send_seq('{8'hA5});
        tick(1);
        check("a5_pre", {31'd0, tx}, 32'd1);
        tick(1);
        check("a5_start", {31'd0, tx}, 32'd0);
        tick(5);
        for (int i = 0; i < 8; i++) begin
            tick(BIT);
            check("a5_bit", {31'd0, tx}, a5_bits[i]);
        end
        tick(BIT * (FRAME - 9));
        check("a5_stop", {31'd0, tx}, 32'd1);
        tick(4);
        check("a5_busy_hi", {31'd0, busy}, 32'd1);
        tick(1);
        check("a5_busy_lo", {31'd0, busy}, 32'd0);
        tick(10);

        // Burst of four: back-to-back frames.
        rx_q.delete();
        send_seq('{8'h00, 8'hFF, 8'h55, 8'hAA});
        tick(4 * FRAME * BIT - 2);
        check("burst_busy_hi", {31'd0, busy}, 32'd1);
        tick(1);
        check("burst_busy_lo", {31'd0, busy}, 32'd0);
        tick(10);
        check_rx("burst_rx", '{8'h00, 8'hFF, 8'h55, 8'hAA});

        // Overfill the 4-deep FIFO: byte 6 is dropped.
        rx_q.delete();
        send_seq('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6});
        check("ovf_full", {31'd0, fifo_full}, 32'd1);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        wait_idle(1000);
        tick(10);
        check("ovf_ovf_held", {31'd0, overflow}, 32'd1);
        check_rx("ovf_rx", '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5});

        // Reset during data bit 3 of 0x3C with two bytes queued.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send_seq('{8'h3C, 8'h11, 8'h22});
        tick(44);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(200);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_tx", {31'd0, tx}, 32'd1);

`ifdef TX_PARITY_EN
        send_seq('{8'h07});
        tick(97);
        check("parity_07", {31'd0, tx}, 32'd1);
        wait_idle(500);
        send_seq('{8'h03});
        tick(97);
        check("parity_03", {31'd0, tx}, 32'd0);
        wait_idle(500);
`endif

        // Random strobe traffic at several densities, with asynchronous resets between some segments.
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 500; c++) begin
                pif.pix_flag = ($urandom_range(0, 99) < rates[seg]);
                pif.pix_data = 8'($urandom);
                tick(1);
            end
            pif.pix_flag = 1'b0;
            if (seg % 2 == 1) begin
                #3 rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
        end
        wait_idle(2000);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
